// File: rtl/encoder_input_filter_if.sv
// Encoder pin / filtered-output bundle between the pin pads and the quadrature decoder.
// The master drives the raw pins and err_clear; the slave returns the conditioned signals.
interface encoder_input_filter_if #(
    parameter int unsigned ERR_CNT_WIDTH = 16
);
    logic                     enc_a_raw;
    logic                     enc_b_raw;
    logic                     enc_i_raw;
    logic                     err_clear;
    logic                     enc_a;
    logic                     enc_b;
    logic                     enc_i;
    logic                     index_pulse;
    logic                     err_pulse;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    modport master (
        output enc_a_raw, enc_b_raw, enc_i_raw, err_clear,
        input  enc_a, enc_b, enc_i, index_pulse, err_pulse, err_count
    );

    modport slave (
        input  enc_a_raw, enc_b_raw, enc_i_raw, err_clear,
        output enc_a, enc_b, enc_i, index_pulse, err_pulse, err_count
    );
endinterface

// File: rtl/encoder_input_filter.sv
// Synchronises and glitch-filters raw encoder pins A/B/index, produces an index strobe,
// and flags/counts illegal quadrature transitions where A and B change on the same edge.
module encoder_input_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    encoder_input_filter_if.slave   bus
);
    localparam int unsigned NCH   = 3;
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned CH_A  = 0;
    localparam int unsigned CH_B  = 1;
    localparam int unsigned CH_I  = 2;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE  = ERR_CNT_WIDTH'(1);

    logic [NCH-1:0]           w_raw;
    logic [NCH-1:0]           w_sync_last;
    logic [NCH-1:0]           w_filt_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt [NCH];
    logic                     w_illegal;
    logic [ERR_CNT_WIDTH-1:0] w_err_count_nxt;

    logic [SYNC_STAGES-1:0]   r_sync [NCH];
    logic [CNT_W-1:0]         r_cnt  [NCH];
    logic [NCH-1:0]           r_filt;
    logic                     r_index_pulse;
    logic                     r_err_pulse;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    assign w_raw = {bus.enc_i_raw, bus.enc_b_raw, bus.enc_a_raw};

    // Per-channel filter: accept a new level only after FILTER_CYCLES consecutive disagreements.
    always_comb begin
        w_sync_last = '0;
        w_filt_nxt  = r_filt;
        for (int ch = 0; ch < NCH; ch++) begin
            w_cnt_nxt[ch]   = '0;
            w_sync_last[ch] = r_sync[ch][SYNC_STAGES-1];
            if (w_sync_last[ch] != r_filt[ch]) begin
                if (r_cnt[ch] == CNT_LAST) begin
                    w_filt_nxt[ch] = w_sync_last[ch];
                end else begin
                    w_cnt_nxt[ch] = r_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Clear takes effect before the coincident event is counted.
    always_comb begin
        w_illegal       = (w_filt_nxt[CH_A] ^ r_filt[CH_A]) & (w_filt_nxt[CH_B] ^ r_filt[CH_B]);
        w_err_count_nxt = r_err_count;
        if (bus.err_clear) begin
            w_err_count_nxt = w_illegal ? ERR_ONE : '0;
        end else if (w_illegal && (r_err_count != ERR_MAX)) begin
            w_err_count_nxt = r_err_count + ERR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_sync[ch] <= '0;
                r_cnt[ch]  <= '0;
            end
            r_filt        <= '0;
            r_index_pulse <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_count   <= '0;
        end else begin
            for (int ch = 0; ch < NCH; ch++) begin
                r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_raw[ch]};
                r_cnt[ch]  <= w_cnt_nxt[ch];
            end
            r_filt        <= w_filt_nxt;
            // Strobes are computed from the next filtered value so they align with it.
            r_index_pulse <= w_filt_nxt[CH_I] & ~r_filt[CH_I];
            r_err_pulse   <= w_illegal;
            r_err_count   <= w_err_count_nxt;
        end
    end

    assign bus.enc_a       = r_filt[CH_A];
    assign bus.enc_b       = r_filt[CH_B];
    assign bus.enc_i       = r_filt[CH_I];
    assign bus.index_pulse = r_index_pulse;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_count   = r_err_count;

endmodule

// File: doc/encoder_input_filter.md
Name: encoder_input_filter

Overview:
Front-end conditioning stage that sits directly upstream of the quadrature decoder core. It synchronises the raw asynchronous encoder pins (A, B, index) into the clk domain and rejects glitches shorter than a programmable number of samples. It drives clean enc_a/enc_b levels into the decoder and a one-cycle index pulse. It also flags illegal quadrature transitions, where A and B change together, and keeps a saturating count of them.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per input; legal range 2..4
FILTER_CYCLES, 4, consecutive differing synchronised samples required to accept a new level; legal range 1..255
ERR_CNT_WIDTH, 16, width of the illegal-transition counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enc_a_raw  input  1  asynchronous encoder channel A pin
enc_b_raw  input  1  asynchronous encoder channel B pin
enc_i_raw  input  1  asynchronous encoder index pin
err_clear  input  1  synchronous clear of err_count
enc_a  output  1  filtered channel A; feeds decoder enc_a
enc_b  output  1  filtered channel B; feeds decoder enc_b
enc_i  output  1  filtered index level
index_pulse  output  1  one-cycle strobe on filtered index rising edge
err_pulse  output  1  one-cycle strobe on illegal A/B transition
err_count  output  ERR_CNT_WIDTH  saturating count of illegal transitions

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. While reset is high at a clk edge, every flop loads 0: all synchroniser stages, filter counters, and all outputs (enc_a, enc_b, enc_i, index_pulse, err_pulse, err_count). This matches the decoder's 00 reset state.
- Reset mid-operation: in-flight filter counts are discarded. A raw input that is high at reset release is re-accepted after the full latency.
- Synchroniser: each raw input passes through its own SYNC_STAGES-deep flop chain. The filter sees only the last stage (sync_x).
- Glitch filter (identical per channel, independent counter of ceil(log2(FILTER_CYCLES+1)) bits):
  - If sync_x == filt_x: cnt is cleared to 0.
  - If sync_x != filt_x and cnt == FILTER_CYCLES-1: filt_x <= sync_x and cnt <= 0.
  - If sync_x != filt_x otherwise: cnt <= cnt+1.
  - A disagreement shorter than FILTER_CYCLES samples is fully rejected and the counter restarts on the next disagreement.
- Latency: a raw level that is stable from before edge 1 appears on the filtered output immediately after edge SYNC_STAGES+FILTER_CYCLES. With defaults that is after edge 6. With FILTER_CYCLES=1 the filter is a plain register stage.
- enc_a, enc_b and enc_i are the filt_x registers directly. No combinational path exists from any raw pin to an output.
- index_pulse: high for exactly the one cycle in which enc_i first reads 1 after reading 0 (registered edge detect). A falling edge gives no pulse.
- Illegal transition: if filt_a and filt_b both change on the same clk edge, err_pulse is high for the following single cycle, i.e. aligned with the new enc_a/enc_b values. err_count increments by 1 on that same edge.
- Single-channel changes never raise err_pulse.
- err_count saturates at 2^ERR_CNT_WIDTH-1 and does not wrap.
- err_clear alone: err_count <= 0 on that edge.
- err_clear with a simultaneous illegal event: err_count <= 1 (clear first, then count the event). err_pulse is unaffected by err_clear.
- Simultaneous events: a legal A change on one edge followed by a B change on the next edge is legal. Index filtering is independent of A/B and never affects the error logic.

Test Plan:
1. Reset with all raw pins high; release reset, hold pins high -> enc_a/enc_b/enc_i rise after edge 6 post-release; index_pulse high for exactly one cycle in which enc_i first reads 1; err_pulse=1 because A and B rose together; err_count=1.
2. Defaults; 3-cycle high glitch on enc_a_raw (otherwise low) -> enc_a stays 0. 4-cycle high pulse -> enc_a high exactly 4 cycles, delayed 6 cycles from raw.
3. Clean forward quadrature sequence 00,01,11,10, each state held 10 cycles -> enc_a/enc_b follow with 6-cycle latency; err_pulse never asserted; err_count stays 0.
4. Raw A and B toggled on the same cycle, 5 times spaced 20 cycles apart -> 5 single-cycle err_pulse strobes; err_count=5. Then err_clear for 1 cycle -> err_count=0. err_clear coincident with an illegal event -> err_count=1.
5. ERR_CNT_WIDTH=2; 5 illegal transitions -> err_count reads 1,2,3,3,3.
6. Assert reset while enc_b_raw has been high for 2 filter samples -> all outputs 0 on the next edge; after release enc_b rises only after a full 6-cycle latency.
